multi_axis_move_engine: RTL and testbench

- Parametrised successor to the single-rate, quarter-turn-only face move block.
- Accepts one cube move at a time over a valid/ready handshake, then drives one of NUM_AXES stepper drivers through four phases: direction setup, N step pulses, settle, done.
- Adds half turns, a programmable step rate, a direction-setup delay, a settle hold and enable polarity selection.
- Sits between the solver move FIFO and the stepper driver board pins.

---
 rtl/multi_axis_move_engine.sv | 196 +++++++++++++++++++
 tb/tb_multi_axis_move_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_axis_move_engine.sv
// multi_axis_move_engine: takes one cube move over valid/ready and runs the
// selected stepper axis through direction setup, N step pulses, settle and
// done. No-op codes complete without touching the driver pins.
module multi_axis_move_engine #(
   parameter int STEPS_PER_QUARTER = 50,
   parameter int STEP_PERIOD       = 1000000,
   parameter int DIR_SETUP_CYCLES  = 100,
   parameter int SETTLE_CYCLES     = 5000000,
   parameter int NUM_AXES          = 6,
   parameter int EN_ACTIVE_LOW     = 1
)(
   input  logic                clock,
   input  logic                reset,
   input  logic [3:0]          move_code,
   input  logic                move_half,
   input  logic                move_valid,
   output logic                move_ready,
   output logic                move_done,
   output logic                busy,
   output logic                dir_pin,
   output logic                step_pin,
   output logic [NUM_AXES-1:0] en_pins
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_STEP   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam int PER_W   = $clog2(STEP_PERIOD);
   localparam int STP_W   = $clog2(2 * STEPS_PER_QUARTER + 1);
   localparam int DLY_MAX = (DIR_SETUP_CYCLES > SETTLE_CYCLES) ? DIR_SETUP_CYCLES : SETTLE_CYCLES;
   localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
   localparam int SETTLE_LAST_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

   localparam logic [PER_W-1:0] PER_LAST    = PER_W'(STEP_PERIOD - 1);
   localparam logic [PER_W-1:0] PER_HIGH    = PER_W'(STEP_PERIOD / 2);
   localparam logic [STP_W-1:0] Q_LAST      = STP_W'(STEPS_PER_QUARTER - 1);
   localparam logic [STP_W-1:0] H_LAST      = STP_W'(2 * STEPS_PER_QUARTER - 1);
   localparam logic [DLY_W-1:0] SETUP_LAST  = DLY_W'(DIR_SETUP_CYCLES - 1);
   localparam logic [DLY_W-1:0] SETTLE_LAST = DLY_W'(SETTLE_LAST_I);
   localparam logic [NUM_AXES-1:0] EN_OFF   = (EN_ACTIVE_LOW != 0) ? {NUM_AXES{1'b1}} : {NUM_AXES{1'b0}};

   // One-hot enable pattern (active-high sense) for an axis index.
   function automatic logic [NUM_AXES-1:0] axis_onehot(input logic [2:0] axis);
      logic [NUM_AXES-1:0] r;
      r = {NUM_AXES{1'b0}};
      for (int i = 0; i < NUM_AXES; i++) begin
         r[i] = (axis == 3'(i));
      end
      return r;
   endfunction

   logic [2:0]          state_r, state_nx_s;
   logic [DLY_W-1:0]    dly_r, dly_nx_s;
   logic [PER_W-1:0]    per_r, per_nx_s;
   logic [STP_W-1:0]    stp_r, stp_nx_s;
   logic [2:0]          axis_r, axis_nx_s;
   logic                dir_r, dir_nx_s;
   logic                half_r, half_nx_s;
   logic                hold_r, hold_nx_s;
   logic                step_r, done_r, busy_r;
   logic [NUM_AXES-1:0] en_r;
   logic                face_s;
   logic                active_s;
   logic [STP_W-1:0]    n_last_s;
   logic [NUM_AXES-1:0] en_act_s;

   assign face_s = (move_code[3:1] != 3'd0) && (move_code[3:1] != 3'd7) &&
                   (int'(move_code[3:1]) <= NUM_AXES);

   assign move_ready = (state_r == S_IDLE) & ~reset;
   assign move_done  = done_r;
   assign busy       = busy_r;
   assign dir_pin    = dir_r;
   assign step_pin   = step_r;
   assign en_pins    = en_r;

   // Next-state, counter and latched-move computation.
   always_comb begin
      state_nx_s = state_r;
      dly_nx_s   = dly_r;
      per_nx_s   = per_r;
      stp_nx_s   = stp_r;
      axis_nx_s  = axis_r;
      dir_nx_s   = dir_r;
      half_nx_s  = half_r;
      hold_nx_s  = hold_r;
      n_last_s   = half_r ? H_LAST : Q_LAST;
      case (state_r)
         S_IDLE: begin
            if (move_valid) begin
               if (face_s) begin
                  state_nx_s = S_SETUP;
                  axis_nx_s  = move_code[3:1] - 3'd1;
                  dir_nx_s   = ~move_code[0];
                  half_nx_s  = move_half;
                  dly_nx_s   = {DLY_W{1'b0}};
               end else begin
                  // No-op: spend one extra cycle in DONE before the pulse.
                  state_nx_s = S_DONE;
                  hold_nx_s  = 1'b1;
               end
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_SETUP: begin
            if (dly_r == SETUP_LAST) begin
               state_nx_s = S_STEP;
               per_nx_s   = {PER_W{1'b0}};
               stp_nx_s   = {STP_W{1'b0}};
            end else begin
               dly_nx_s = dly_r + DLY_W'(1);
            end
         end
         S_STEP: begin
            if (per_r == PER_LAST) begin
               per_nx_s = {PER_W{1'b0}};
               if (stp_r == n_last_s) begin
                  if (SETTLE_CYCLES == 0) begin
                     state_nx_s = S_DONE;
                  end else begin
                     state_nx_s = S_SETTLE;
                     dly_nx_s   = {DLY_W{1'b0}};
                  end
               end else begin
                  stp_nx_s = stp_r + STP_W'(1);
               end
            end else begin
               per_nx_s = per_r + PER_W'(1);
            end
         end
         S_SETTLE: begin
            if (dly_r == SETTLE_LAST) begin
               state_nx_s = S_DONE;
            end else begin
               dly_nx_s = dly_r + DLY_W'(1);
            end
         end
         S_DONE: begin
            if (hold_r) begin
               hold_nx_s = 1'b0;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase
   end

   // Output values that follow from the next state, so the pins are registered.
   always_comb begin
      active_s = (state_nx_s == S_SETUP) || (state_nx_s == S_STEP) || (state_nx_s == S_SETTLE);
      if (active_s) begin
         en_act_s = axis_onehot(axis_nx_s);
      end else begin
         en_act_s = {NUM_AXES{1'b0}};
      end
   end

   // State, counters and registered pin outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= S_IDLE;
         dly_r   <= {DLY_W{1'b0}};
         per_r   <= {PER_W{1'b0}};
         stp_r   <= {STP_W{1'b0}};
         axis_r  <= 3'd0;
         dir_r   <= 1'b0;
         half_r  <= 1'b0;
         hold_r  <= 1'b0;
         step_r  <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         en_r    <= EN_OFF;
      end else begin
         state_r <= state_nx_s;
         dly_r   <= dly_nx_s;
         per_r   <= per_nx_s;
         stp_r   <= stp_nx_s;
         axis_r  <= axis_nx_s;
         dir_r   <= dir_nx_s;
         half_r  <= half_nx_s;
         hold_r  <= hold_nx_s;
         step_r  <= (state_nx_s == S_STEP) && (per_nx_s < PER_HIGH);
         done_r  <= (state_nx_s == S_DONE) && !hold_nx_s;
         busy_r  <= (state_nx_s != S_IDLE);
         en_r    <= (EN_ACTIVE_LOW != 0) ? ~en_act_s : en_act_s;
      end
   end

endmodule

// File: tb/tb_multi_axis_move_engine.sv
// Directed bench for multi_axis_move_engine with small timing parameters.
module tb_multi_axis_move_engine;

   logic       clock;
   logic       reset;
   logic [3:0] move_code;
   logic       move_half;
   logic       move_valid;
   logic       move_ready;
   logic       move_done;
   logic       busy;
   logic       dir_pin;
   logic       step_pin;
   logic [5:0] en_pins;

   int tests_run;
   int tests_failed;

   multi_axis_move_engine #(
      .STEPS_PER_QUARTER(3),
      .STEP_PERIOD(4),
      .DIR_SETUP_CYCLES(2),
      .SETTLE_CYCLES(3),
      .NUM_AXES(6),
      .EN_ACTIVE_LOW(1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .move_code(move_code),
      .move_half(move_half),
      .move_valid(move_valid),
      .move_ready(move_ready),
      .move_done(move_done),
      .busy(busy),
      .dir_pin(dir_pin),
      .step_pin(step_pin),
      .en_pins(en_pins)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      move_valid = 1'b0;
      move_code = 4'd0;
      move_half = 1'b0;
      tick(); tick(); tick();
      reset = 1'b0;
      #1;
      tests_run++;
      if (en_pins !== 6'b111111) begin tests_failed++; $display("FAIL reset_en got %b want %b", en_pins, 6'b111111); end
      tests_run++;
      if (step_pin !== 1'b0) begin tests_failed++; $display("FAIL reset_step got %b want 0", step_pin); end
      tests_run++;
      if (move_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", move_ready); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
      tests_run++;
      if (move_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", move_done); end
      tests_run++;
      if (dir_pin !== 1'b0) begin tests_failed++; $display("FAIL reset_dir got %b want 0", dir_pin); end
   endtask

   // Face move: checks every cycle from accept+1 through the cycle after move_done.
   task automatic test_face(input logic [3:0] code, input logic half,
                            input logic [5:0] exp_en, input logic exp_dir, input int n_steps);
      int total;
      int edges;
      logic prev_step;
      logic exp_step;
      total = 1 + 2 + n_steps * 4 + 3;
      edges = 0;
      prev_step = 1'b0;
      move_code = code;
      move_half = half;
      move_valid = 1'b1;
      tick();
      move_valid = 1'b0;
      for (int c = 1; c <= total; c++) begin
         if (c >= 3 && c < 3 + n_steps * 4) exp_step = (((c - 3) % 4) < 2);
         else exp_step = 1'b0;
         if (step_pin === 1'b1 && prev_step === 1'b0) edges++;
         prev_step = step_pin;
         tests_run++;
         if (c < total) begin
            if (en_pins !== exp_en || move_done !== 1'b0 || busy !== 1'b1 ||
                dir_pin !== exp_dir || step_pin !== exp_step || move_ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL face_cycle code=%0d c=%0d got en=%b done=%b busy=%b dir=%b step=%b rdy=%b want en=%b done=0 busy=1 dir=%b step=%b rdy=0",
                        code, c, en_pins, move_done, busy, dir_pin, step_pin, move_ready, exp_en, exp_dir, exp_step);
            end
         end else begin
            if (move_done !== 1'b1 || en_pins !== 6'b111111 || step_pin !== 1'b0) begin
               tests_failed++;
               $display("FAIL face_done code=%0d c=%0d got done=%b en=%b step=%b want done=1 en=111111 step=0",
                        code, c, move_done, en_pins, step_pin);
            end
         end
         tick();
      end
      tests_run++;
      if (edges != n_steps) begin tests_failed++; $display("FAIL face_pulses code=%0d got %0d want %0d", code, edges, n_steps); end
      tests_run++;
      if (move_done !== 1'b0 || busy !== 1'b0 || move_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL face_after code=%0d got done=%b busy=%b rdy=%b want 0 0 1", code, move_done, busy, move_ready);
      end
   endtask

   task automatic test_noop(input logic [3:0] code, input logic exp_dir);
      move_code = code;
      move_half = 1'b0;
      move_valid = 1'b1;
      tick();
      move_valid = 1'b0;
      tests_run++;
      if (move_done !== 1'b0 || busy !== 1'b1 || en_pins !== 6'b111111 || step_pin !== 1'b0 || dir_pin !== exp_dir) begin
         tests_failed++;
         $display("FAIL noop_c1 got done=%b busy=%b en=%b step=%b dir=%b want 0 1 111111 0 %b",
                  move_done, busy, en_pins, step_pin, dir_pin, exp_dir);
      end
      tick();
      tests_run++;
      if (move_done !== 1'b1 || en_pins !== 6'b111111 || step_pin !== 1'b0 || dir_pin !== exp_dir) begin
         tests_failed++;
         $display("FAIL noop_c2 got done=%b en=%b step=%b dir=%b want 1 111111 0 %b",
                  move_done, en_pins, step_pin, dir_pin, exp_dir);
      end
      tick();
      tests_run++;
      if (move_done !== 1'b0 || busy !== 1'b0 || move_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL noop_after got done=%b busy=%b rdy=%b want 0 0 1", move_done, busy, move_ready);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      int bad_accept;
      bad_accept = 0;
      move_code = 4'd4;
      move_half = 1'b0;
      move_valid = 1'b1;
      tick();
      c = 1;
      while (move_done !== 1'b1 && c < 40) begin
         if (busy === 1'b1 && (move_ready !== 1'b0 || en_pins !== 6'b111101)) bad_accept++;
         tick();
         c++;
      end
      tests_run++;
      if (c != 18) begin tests_failed++; $display("FAIL b2b_first_latency got %0d want 18", c); end
      tests_run++;
      if (bad_accept != 0) begin tests_failed++; $display("FAIL b2b_busy_accept got %0d bad cycles want 0", bad_accept); end
      move_code = 4'd6;
      tick();
      tests_run++;
      if (move_ready !== 1'b1 || busy !== 1'b0 || en_pins !== 6'b111111) begin
         tests_failed++;
         $display("FAIL b2b_idle got rdy=%b busy=%b en=%b want 1 0 111111", move_ready, busy, en_pins);
      end
      tick();
      move_valid = 1'b0;
      tests_run++;
      if (en_pins !== 6'b111011 || busy !== 1'b1 || dir_pin !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_second_accept got en=%b busy=%b dir=%b want 111011 1 1", en_pins, busy, dir_pin);
      end
      c = 1;
      while (move_done !== 1'b1 && c < 40) begin
         tick();
         c++;
      end
      tests_run++;
      if (c != 18) begin tests_failed++; $display("FAIL b2b_second_latency got %0d want 18", c); end
      tick();
   endtask

   task automatic test_reset_mid_move();
      int dones;
      move_code = 4'd8;
      move_half = 1'b0;
      move_valid = 1'b1;
      tick();
      move_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      tests_run++;
      if (step_pin !== 1'b1 || en_pins !== 6'b110111) begin
         tests_failed++;
         $display("FAIL mid_pulse2 got step=%b en=%b want 1 110111", step_pin, en_pins);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      tests_run++;
      if (en_pins !== 6'b111111 || step_pin !== 1'b0 || move_ready !== 1'b1 ||
          busy !== 1'b0 || move_done !== 1'b0 || dir_pin !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset got en=%b step=%b rdy=%b busy=%b done=%b dir=%b want 111111 0 1 0 0 0",
                  en_pins, step_pin, move_ready, busy, move_done, dir_pin);
      end
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (move_done === 1'b1 || busy !== 1'b0) dones++;
      end
      tests_run++;
      if (dones != 0) begin tests_failed++; $display("FAIL mid_no_done got %0d done/busy cycles want 0", dones); end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_face(4'd2, 1'b0, 6'b111110, 1'b1, 3);
      test_noop(4'd15, 1'b1);
      test_face(4'd11, 1'b1, 6'b101111, 1'b0, 6);
      test_noop(4'd0, 1'b0);
      test_back_to_back();
      test_reset_mid_move();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
